// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the neuron datapath stages.
// Default number format is Q7.24 in a 32-bit signed word.
package nn_fixed_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_FRAC_BITS  = 24;
  localparam int DEF_NUM_INPUTS = 8;
  // Product shifted back to FracBits needs 2*Width-FracBits bits; 8 guard
  // bits let up to 256 worst-case products accumulate without wrapping.
  localparam int DEF_ACC_WIDTH  = 2 * DEF_WIDTH - DEF_FRAC_BITS + 8;

  // 1.0 in the default format.
  localparam logic [DEF_WIDTH-1:0] ONE     = DEF_WIDTH'(1) << DEF_FRAC_BITS;
  // Saturation rails in the default format.
  localparam logic [DEF_WIDTH-1:0] MAX_POS = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] MAX_NEG = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SAT   = 2'd2,
    ST_OUT   = 2'd3
  } mac_state_e;

endpackage

// File: rtl/neuron_mac_accumulator_if.sv
// Stream and control bundle of the neuron MAC stage.
// slave = the accumulator, master = whoever feeds and drains it.
interface neuron_mac_accumulator_if
  import nn_fixed_pkg::*;
#(
  parameter int Width = DEF_WIDTH
);

  logic             start;
  logic [Width-1:0] bias;
  logic             inValid;
  logic             inReady;
  logic [Width-1:0] inData;
  logic [Width-1:0] inWeight;
  logic             OutValid;
  logic             OutReady;
  logic [Width-1:0] OutData;
  logic             satFlag;
  logic             busy;

  modport slave (
    input  start, bias, inValid, inData, inWeight, OutReady,
    output inReady, OutValid, OutData, satFlag, busy
  );

  modport master (
    output start, bias, inValid, inData, inWeight, OutReady,
    input  inReady, OutValid, OutData, satFlag, busy
  );

endinterface

// File: rtl/fixed_mul_shift.sv
// Signed fixed-point multiply: full-precision product, arithmetic shift
// right by FracBits (floor rounding), sign-extended to AccWidth.
// Purely combinational so other neuron stages can reuse it.
module fixed_mul_shift
  import nn_fixed_pkg::*;
#(
  parameter int Width    = DEF_WIDTH,
  parameter int FracBits = DEF_FRAC_BITS,
  // Must exceed 2*Width-FracBits so the shifted product always fits.
  parameter int AccWidth = 2 * Width - FracBits + 8
) (
  input  logic signed [Width-1:0]    a_i,
  input  logic signed [Width-1:0]    b_i,
  output logic signed [AccWidth-1:0] p_o
);

  localparam int ProdWidth = 2 * Width;
  localparam int KeepWidth = ProdWidth - FracBits;

  logic signed [ProdWidth-1:0] a_ext_s;
  logic signed [ProdWidth-1:0] b_ext_s;
  logic signed [ProdWidth-1:0] prod_s;
  logic                        unused_frac_s;

  assign a_ext_s = {{Width{a_i[Width-1]}}, a_i};
  assign b_ext_s = {{Width{b_i[Width-1]}}, b_i};
  assign prod_s  = a_ext_s * b_ext_s;

  // Dropping the low FracBits bits of a two's-complement value is an
  // arithmetic shift, i.e. truncation toward minus infinity.
  assign p_o = {{(AccWidth-KeepWidth){prod_s[ProdWidth-1]}},
                prod_s[ProdWidth-1:FracBits]};

  // The discarded fraction bits are intentionally dropped.
  assign unused_frac_s = ^prod_s[FracBits-1:0];

endmodule

// File: rtl/neuron_mac_accumulator.sv
// Weighted-sum stage of one neuron: bias + sum(inData*inWeight) over
// NumInputs stream beats, saturated to Width bits and handed downstream
// to the activation limiter over a valid/ready output.
module neuron_mac_accumulator
  import nn_fixed_pkg::*;
#(
  parameter int Width     = DEF_WIDTH,
  parameter int FracBits  = DEF_FRAC_BITS,
  parameter int NumInputs = DEF_NUM_INPUTS,
  parameter int AccWidth  = 2 * Width - FracBits + 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  neuron_mac_accumulator_if.slave   bus
);

  localparam int CntW = $clog2(NumInputs + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(NumInputs - 1);

  // Representable range of the output word, widened to the accumulator.
  localparam logic signed [AccWidth-1:0] SatHi =
    {{(AccWidth-Width+1){1'b0}}, {(Width-1){1'b1}}};
  localparam logic signed [AccWidth-1:0] SatLo =
    {{(AccWidth-Width+1){1'b1}}, {(Width-1){1'b0}}};
  localparam logic [Width-1:0] RailPos = {1'b0, {(Width-1){1'b1}}};
  localparam logic [Width-1:0] RailNeg = {1'b1, {(Width-1){1'b0}}};

  mac_state_e                state_q, state_d;
  logic signed [AccWidth-1:0] acc_q, acc_d;
  logic [CntW-1:0]           count_q, count_d;
  logic [Width-1:0]          out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      sat_q, sat_d;
  logic                      in_ready_q, in_ready_d;
  logic                      busy_q, busy_d;

  logic                      beat_s;
  logic signed [AccWidth-1:0] prod_s;
  logic signed [AccWidth-1:0] bias_ext_s;

  fixed_mul_shift #(
    .Width    (Width),
    .FracBits (FracBits),
    .AccWidth (AccWidth)
  ) u_mul (
    .a_i (bus.inData),
    .b_i (bus.inWeight),
    .p_o (prod_s)
  );

  assign bias_ext_s = {{(AccWidth-Width){bus.bias[Width-1]}}, bus.bias};
  assign beat_s     = bus.inValid & in_ready_q;

  // Next-state, accumulator and output-register logic of the evaluation FSM.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d   = bias_ext_s;
          count_d = '0;
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCUM: begin
        if (beat_s) begin
          acc_d   = acc_q + prod_s;
          count_d = count_q + CntW'(1);
          if (count_q == LastIdx) begin
            state_d = ST_SAT;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end

      ST_SAT: begin
        if (acc_q > SatHi) begin
          out_data_d = RailPos;
          sat_d      = 1'b1;
        end else if (acc_q < SatLo) begin
          out_data_d = RailNeg;
          sat_d      = 1'b1;
        end else begin
          out_data_d = acc_q[Width-1:0];
          sat_d      = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end

      ST_OUT: begin
        // Result and flag stay frozen until the downstream takes them.
        if (bus.OutReady) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Handshake-side status is registered alongside the state it decodes.
    in_ready_d = (state_d == ST_ACCUM);
    busy_d     = (state_d != ST_IDLE);
  end

  // State, datapath and output registers; reset discards any partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.inReady  = in_ready_q;
  assign bus.OutValid = out_valid_q;
  assign bus.OutData  = out_data_q;
  assign bus.satFlag  = sat_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Scoreboard bench for neuron_mac_accumulator with NumInputs=4, Q7.24.
module tb_neuron_mac_accumulator;
  import nn_fixed_pkg::*;

  localparam int W  = 32;
  localparam int FB = 24;
  localparam int NI = 4;
  localparam longint HI = 64'sd2147483647;
  localparam longint LO = -HI - 64'sd1;

  typedef struct packed {
    logic         sat;
    logic [W-1:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatched;
  int   hs_count;
  int   evals_done;
  exp_t sb_q[$];
  logic [W-1:0] d[NI];
  logic [W-1:0] w[NI];

  neuron_mac_accumulator_if #(.Width(W)) bus ();

  neuron_mac_accumulator #(
    .Width     (W),
    .FracBits  (FB),
    .NumInputs (NI)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output handshakes as the downstream would see them.
  always @(posedge clk) begin
    if (rst_n && bus.OutValid && bus.OutReady) hs_count++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent reference: 64-bit integer products, floor shift, clip.
  function automatic exp_t model(input logic [W-1:0] b, input logic [W-1:0] dv[NI],
                                 input logic [W-1:0] wv[NI]);
    longint acc;
    longint p;
    exp_t   r;
    acc = longint'($signed(b));
    for (int i = 0; i < NI; i++) begin
      p   = longint'($signed(dv[i])) * longint'($signed(wv[i]));
      acc = acc + (p >>> FB);
    end
    if (acc > HI)      r = {1'b1, MAX_POS};
    else if (acc < LO) r = {1'b1, MAX_NEG};
    else               r = {1'b0, acc[W-1:0]};
    return r;
  endfunction

  task automatic run_eval(input logic [W-1:0] b, input int max_gap, input int hold,
                          input bit early_ready, input bit noise);
    exp_t got_e;
    int   gaps;
    int   k;
    sb_q.push_back(model(b, d, w));
    bus.bias     = b;
    bus.start    = 1'b1;
    bus.OutReady = early_ready;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bias  = $urandom();
    check_val("busy_after_start", 64'(bus.busy), 64'd1);
    for (int i = 0; i < NI; i++) begin
      gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gaps) begin
        if (noise) bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      bus.inValid  = 1'b1;
      bus.inData   = d[i];
      bus.inWeight = w[i];
      k = 0;
      while (!bus.inReady && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
      if (k >= 20) check_val("inready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      bus.inValid  = 1'b0;
      bus.inData   = $urandom();
      bus.inWeight = $urandom();
    end
    // One edge after the last beat the result is still being clipped.
    check_val("outvalid_after_last_beat", 64'(bus.OutValid), 64'd0);
    check_val("inready_dropped", 64'(bus.inReady), 64'd0);
    @(posedge clk); #1;
    check_val("outvalid_two_cycles", 64'(bus.OutValid), 64'd1);
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 64'd0, 64'd1);
      got_e = '0;
    end else begin
      got_e = sb_q.pop_front();
    end
    check_val("out_data", 64'(bus.OutData), 64'(got_e.data));
    check_val("sat_flag", 64'(bus.satFlag), 64'(got_e.sat));
    if (!early_ready) begin
      repeat (hold) begin
        if (noise) bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_val("hold_valid", 64'(bus.OutValid), 64'd1);
        check_val("hold_data", 64'(bus.OutData), 64'(got_e.data));
        check_val("hold_sat", 64'(bus.satFlag), 64'(got_e.sat));
      end
      bus.OutReady = 1'b1;
      bus.start    = noise;
      @(posedge clk); #1;
      bus.OutReady = 1'b0;
      bus.start    = 1'b0;
    end else begin
      @(posedge clk); #1;
      bus.OutReady = 1'b0;
    end
    check_val("outvalid_cleared", 64'(bus.OutValid), 64'd0);
    check_val("idle_after_handshake", 64'(bus.busy), 64'd0);
    evals_done++;
  endtask

  task automatic fill(input logic [W-1:0] dv, input logic [W-1:0] wv);
    for (int i = 0; i < NI; i++) begin
      d[i] = dv;
      w[i] = wv;
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    hs_count     = 0;
    evals_done   = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.bias     = '0;
    bus.inValid  = 1'b0;
    bus.inData   = '0;
    bus.inWeight = '0;
    bus.OutReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_outvalid", 64'(bus.OutValid), 64'd0);
    check_val("rst_outdata", 64'(bus.OutData), 64'd0);
    check_val("rst_sat", 64'(bus.satFlag), 64'd0);
    check_val("rst_inready", 64'(bus.inReady), 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1.0 * 0.5 four times -> 2.0
    fill(ONE, 32'h0080_0000);
    run_eval(32'h0, 0, 0, 1'b0, 1'b0);
    // -1.0 * 1.0 four times + 0.25 -> -3.75
    fill(32'hFF00_0000, ONE);
    run_eval(32'h0040_0000, 0, 0, 1'b0, 1'b0);
    // Positive and negative saturation
    fill(32'h7F00_0000, ONE);
    run_eval(32'h0, 0, 0, 1'b0, 1'b0);
    fill(32'h8100_0000, ONE);
    run_eval(32'h0, 0, 0, 1'b0, 1'b0);

    // Same random vector gap-free, then with gaps, stalls and stray starts
    for (int i = 0; i < NI; i++) begin
      d[i] = $urandom();
      w[i] = {{8{1'b0}}, 24'($urandom())};
    end
    run_eval(32'h0123_4567, 0, 0, 1'b0, 1'b0);
    run_eval(32'h0123_4567, 3, 5, 1'b0, 1'b1);
    // OutReady already high before OutValid
    run_eval(32'hFFF0_0000, 2, 0, 1'b1, 1'b0);

    // Reset after two of four beats: partial sum discarded
    fill(ONE, ONE);
    bus.bias  = 32'h0100_0000;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.inValid  = 1'b1;
      bus.inData   = d[i];
      bus.inWeight = w[i];
      @(posedge clk); #1;
    end
    bus.inValid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_outvalid", 64'(bus.OutValid), 64'd0);
    check_val("async_rst_outdata", 64'(bus.OutData), 64'd0);
    check_val("async_rst_sat", 64'(bus.satFlag), 64'd0);
    check_val("async_rst_inready", 64'(bus.inReady), 64'd0);
    check_val("async_rst_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_val("no_valid_after_rst", 64'(bus.OutValid), 64'd0);
    end
    run_eval(32'h0100_0000, 0, 0, 1'b0, 1'b0);

    // Floor truncation: -2^-24 * 2^-24 rounds down to -2^-24
    fill(32'h0, 32'h0);
    d[0] = 32'hFFFF_FFFF;
    w[0] = 32'h0000_0001;
    run_eval(32'h0, 0, 0, 1'b0, 1'b0);

    check_val("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    check_val("handshake_count", 64'(hs_count), 64'(evals_done));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
